// File: rtl/cpx_result_logger_if.sv
// cpx_result_logger_if
//   Bundles the CPX capture inputs, the uart_tx byte handshake and the
//   logger status outputs.
//   master : testbench / system side (drives cpx_req, cpx_data, uart_busy)
//   slave  : logger side (drives tx_en, tx_data, fifo_full, drop_cnt, idle)
//   cpx_req   [7:0]   FPU CPX request vector
//   cpx_data  [144:0] FPU CPX packet, bit 144 = valid
//   uart_busy         high while the UART is transmitting
//   tx_en             one-cycle byte send strobe
//   tx_data   [7:0]   byte to send
//   fifo_full         record FIFO full
//   drop_cnt  [7:0]   saturating overflow drop counter
//   idle              logger idle, FIFO empty, no CPX request
interface cpx_result_logger_if;
  logic [7:0]   cpx_req;
  logic [144:0] cpx_data;
  logic         uart_busy;
  logic         tx_en;
  logic [7:0]   tx_data;
  logic         fifo_full;
  logic [7:0]   drop_cnt;
  logic         idle;

  modport master (
    output cpx_req, cpx_data, uart_busy,
    input  tx_en, tx_data, fifo_full, drop_cnt, idle
  );

  modport slave (
    input  cpx_req, cpx_data, uart_busy,
    output tx_en, tx_data, fifo_full, drop_cnt, idle
  );
endinterface

// File: rtl/cpx_result_logger.sv
// cpx_result_logger
//   Captures every valid FPU CPX return packet into a small record FIFO and
//   serializes each record as a framed byte stream to a uart_tx byte port.
//   Never back-pressures the FPU: packets arriving while the FIFO is full
//   (with no same-edge pop) are dropped and counted.
//   Frame: A5, {type,00,thread}, {000,flags}, {000,cc}, result[63:0] MSB
//   first, then an optional XOR checksum of bytes 1..11.
// Ports
//   clk     system clock
//   arst_l  asynchronous active-low reset
//   bus     cpx_result_logger_if.slave (see interface file for signals)
// Parameters
//   FIFO_DEPTH  record FIFO entries, power of two, >= 2
// Build option
//   CPX_RESULT_LOGGER_CHECKSUM_EN  when defined, appends the checksum byte
//                                  (13-byte frames); otherwise 12-byte frames.
module cpx_result_logger #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               arst_l,
  cpx_result_logger_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
`ifdef CPX_RESULT_LOGGER_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd12;
`else
  localparam logic [3:0] LAST_IDX = 4'd11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  // Record layout: {type[3:0], thread[1:0], flags[4:0], cc[4:0], result[63:0]}
  function automatic logic [7:0] data_byte(input logic [79:0] rec, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = 8'hA5;
      4'd1:    b = {rec[79:76], 2'b00, rec[75:74]};
      4'd2:    b = {3'b000, rec[73:69]};
      4'd3:    b = {3'b000, rec[68:64]};
      4'd4:    b = rec[63:56];
      4'd5:    b = rec[55:48];
      4'd6:    b = rec[47:40];
      4'd7:    b = rec[39:32];
      4'd8:    b = rec[31:24];
      4'd9:    b = rec[23:16];
      4'd10:   b = rec[15:8];
      4'd11:   b = rec[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef CPX_RESULT_LOGGER_CHECKSUM_EN
  function automatic logic [7:0] checksum(input logic [79:0] rec);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < 12; i++) x = x ^ data_byte(rec, 4'(i));
    return x;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [79:0] rec, input logic [3:0] idx);
    return (idx == 4'd12) ? checksum(rec) : data_byte(rec, idx);
  endfunction
`else
  function automatic logic [7:0] frame_byte(input logic [79:0] rec, input logic [3:0] idx);
    return data_byte(rec, idx);
  endfunction
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    idx_q, idx_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          fifo_full_q, fifo_full_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [79:0]   frame_q, frame_d;
  logic [79:0]   mem_q [FIFO_DEPTH];

  logic        push, pop, empty, full, accept;
  logic [79:0] rec_in;
  logic        unused_cpx_bits;

  assign unused_cpx_bits = ^{bus.cpx_data[139:136], bus.cpx_data[133:77],
                             bus.cpx_data[71:70], bus.cpx_data[64]};

  assign rec_in = {bus.cpx_data[143:140], bus.cpx_data[135:134],
                   bus.cpx_data[76:72], bus.cpx_data[69:65], bus.cpx_data[63:0]};

  // FIFO bookkeeping: pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    push   = bus.cpx_data[144];
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop    = (state_q == S_IDLE) && !empty;
    // A push into a full FIFO still fits when the IDLE pop frees a slot on the same edge.
    accept = push && (!full || pop);

    wr_ptr_d = accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop    ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    fifo_full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    drop_cnt_d = drop_cnt_q;
    if (push && !accept && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Frame transmitter: one byte per uart_busy rise/fall cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          frame_d = mem_q[rd_ptr_q[AW-1:0]];
          idx_d   = 4'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.uart_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = frame_byte(frame_q, idx_q);
          state_d   = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.uart_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.uart_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= 4'd0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      fifo_full_q <= 1'b0;
      drop_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      fifo_full_q <= fifo_full_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Record storage and frame register hold data only; validity comes from the control state.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
    frame_q <= frame_d;
  end

  assign bus.tx_en     = tx_en_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.fifo_full = fifo_full_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.idle      = (state_q == S_IDLE) && empty && (bus.cpx_req == 8'h00);
endmodule

// File: tb/tb_cpx_result_logger.sv
// tb_cpx_result_logger
//   Directed bench for cpx_result_logger with FIFO_DEPTH=4. A frame model
//   builds the expected byte stream of every accepted packet; one monitor
//   compares every tx_en strobe against it and checks the uart handshake.
module tb_cpx_result_logger;
`ifdef CPX_RESULT_LOGGER_CHECKSUM_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  typedef logic [7:0] frame_t [13];

  logic clk = 1'b0;
  logic arst_l = 1'b0;
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  int   busy_len = 3;
  int   fall_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   strobes = 0;
  int   exp_drop = 0;
  logic [7:0] exp_q [$];

  cpx_result_logger_if bus();
  assign bus.uart_busy = force_busy | model_busy;

  cpx_result_logger #(.FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Frame as defined for the host: sync, header, flags, cc, result MSB first, XOR of 1..11.
  task automatic make_frame(input logic [3:0] typ, input logic [1:0] thr, input logic [4:0] flg,
                            input logic [4:0] cc, input logic [63:0] res, output frame_t f);
    logic [7:0] cs;
    f[0] = 8'hA5;
    f[1] = {typ, 2'b00, thr};
    f[2] = {3'b000, flg};
    f[3] = {3'b000, cc};
    for (int i = 0; i < 8; i++) f[4+i] = res[63-8*i -: 8];
    cs = 8'h00;
    for (int i = 1; i < 12; i++) cs = cs ^ f[i];
    f[12] = cs;
  endtask

  // Drives one valid packet for one cycle (caller clears valid after a run).
  task automatic put_pkt(input logic [3:0] typ, input logic [1:0] thr, input logic [4:0] flg,
                         input logic [4:0] cc, input logic [63:0] res, input bit acc);
    logic [144:0] d;
    frame_t f;
    d = '1;
    d[143:140] = typ;
    d[135:134] = thr;
    d[76:72]   = flg;
    d[69:65]   = cc;
    d[63:0]    = res;
    d[144]     = 1'b1;
    bus.cpx_data = d;
    if (acc) begin
      make_frame(typ, thr, flg, cc, res, f);
      for (int i = 0; i < NB; i++) exp_q.push_back(f[i]);
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
    @(negedge clk);
  endtask

  task automatic end_pkts();
    bus.cpx_data[144] = 1'b0;
  endtask

  task automatic put_idx(input int i, input bit acc);
    put_pkt(4'(i + 2), 2'(i), 5'(i * 3), 5'(31 - i), {32'hC0DE0000 | 32'(i), 32'(i * 7919)}, acc);
  endtask

  task automatic wait_drain(input string nm, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.idle) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n < max_cyc), 64'd1);
    repeat (20) @(negedge clk);
  endtask

  // UART model: busy rises one cycle after a tx_en strobe and stays high busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (arst_l && bus.tx_en) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 model_busy = 1'b0;
        fall_cnt++;
      end
    end
  end

  // Monitor: every strobed byte against the model, plus handshake rules.
  initial begin
    logic prev_en, have_last, seen_rise, seen_fall;
    logic [7:0] last_byte;
    prev_en = 1'b0; have_last = 1'b0; seen_rise = 1'b0; seen_fall = 1'b0; last_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!arst_l) begin
        exp_q.delete();
        have_last = 1'b0;
        seen_rise = 1'b0;
        seen_fall = 1'b0;
      end else if (bus.tx_en) begin
        chk("tx_en_one_cycle", 64'(prev_en), 64'd0);
        if (have_last) chk("tx_en_after_busy_cycle", 64'({seen_rise, seen_fall}), 64'd3);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: actual=%0h required=no byte", bus.tx_data);
        end else begin
          chk("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
        end
        strobes++;
        last_byte = bus.tx_data;
        have_last = 1'b1;
        seen_rise = 1'b0;
        seen_fall = 1'b0;
      end else if (have_last) begin
        if (bus.uart_busy) begin
          seen_rise = 1'b1;
          chk("tx_data_stable", 64'(bus.tx_data), 64'(last_byte));
        end else if (seen_rise) begin
          seen_fall = 1'b1;
        end
      end
      prev_en = bus.tx_en;
    end
  end

  initial begin
    frame_t f;
    logic [7:0] lit [13];
    int lat, n, cnt, s0, fc;

    bus.cpx_req  = 8'h00;
    bus.cpx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", 64'(bus.tx_en), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'h00);
    chk("rst_fifo_full", 64'(bus.fifo_full), 64'd0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    arst_l = 1'b1;
    @(negedge clk);
    bus.cpx_req = 8'h04;
    #1 chk("idle_with_req", 64'(bus.idle), 64'd0);
    bus.cpx_req = 8'h00;
    #1 chk("idle_no_req", 64'(bus.idle), 64'd1);

    // Pin the frame model with hand-computed bytes.
    lit = '{8'hA5, 8'h81, 8'h01, 8'h00, 8'h3F, 8'hF0, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h4F};
    make_frame(4'h8, 2'd1, 5'h01, 5'h00, 64'h3FF0000000000000, f);
    for (int i = 0; i < NB; i++) chk("model_frame_literal", 64'(f[i]), 64'(lit[i]));

    // Single packet, long busy: latency, bytes and handshake.
    busy_len = 10;
    @(negedge clk);
    s0 = strobes;
    put_pkt(4'h8, 2'd1, 5'h01, 5'h00, 64'h3FF0000000000000, 1'b1);
    end_pkts();
    lat = 1;
    while (!bus.tx_en && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_tx_en_latency", 64'(lat), 64'd3);
    wait_drain("single_drain", 2000);
    chk("single_frame_len", 64'(strobes - s0), 64'(NB));

    // Burst of 6 with UART held busy: 5 kept, 1 dropped.
    busy_len = 3;
    force_busy = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 6; i++) put_idx(i, i < 5);
    end_pkts();
    chk("burst_drop_cnt", 64'(bus.drop_cnt), 64'd1);
    chk("burst_fifo_full", 64'(bus.fifo_full), 64'd1);
    chk("burst_idle", 64'(bus.idle), 64'd0);
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    wait_drain("burst_drain", 3000);
    chk("burst_bytes", 64'(strobes - s0), 64'(5 * NB));
    chk("burst_fifo_empty", 64'(bus.fifo_full), 64'd0);

    // Push while full on the same edge as the IDLE pop.
    s0 = strobes;
    put_idx(10, 1'b1);
    end_pkts();
    repeat (2) @(negedge clk);
    for (int i = 11; i < 15; i++) put_idx(i, 1'b1);
    end_pkts();
    chk("sim_full_before", 64'(bus.fifo_full), 64'd1);
    n = 0;
    while (strobes < s0 + NB && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("sim_first_frame_done", 64'(strobes >= s0 + NB), 64'd1);
    fc = fall_cnt;
    n = 0;
    while (fall_cnt == fc && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sim_busy_fell", 64'(fall_cnt != fc), 64'd1);
    @(negedge clk);
    put_idx(15, 1'b1);
    end_pkts();
    chk("sim_drop_unchanged", 64'(bus.drop_cnt), 64'(exp_drop));
    chk("sim_still_full", 64'(bus.fifo_full), 64'd1);
    wait_drain("sim_drain", 4000);

    // Saturation: 300 overflows.
    force_busy = 1'b1;
    for (int i = 0; i < 305; i++) put_idx(20 + i, i < 5);
    end_pkts();
    chk("sat_model", 64'(exp_drop), 64'd255);
    chk("sat_drop_cnt", 64'(bus.drop_cnt), 64'd255);
    chk("sat_fifo_full", 64'(bus.fifo_full), 64'd1);
    for (int i = 0; i < 5; i++) put_idx(400 + i, 1'b0);
    end_pkts();
    chk("sat_drop_hold", 64'(bus.drop_cnt), 64'd255);
    force_busy = 1'b0;
    wait_drain("sat_drain", 4000);

    // Reset while byte 6 is on the wire.
    put_idx(500, 1'b1);
    end_pkts();
    cnt = 0;
    n = 0;
    while (cnt < 7 && n < 500) begin
      @(negedge clk);
      n++;
      if (bus.tx_en) cnt++;
    end
    chk("reach_byte6", 64'(cnt), 64'd7);
    #2 arst_l = 1'b0;
    exp_drop = 0;
    #1;
    chk("midrst_tx_en", 64'(bus.tx_en), 64'd0);
    chk("midrst_tx_data", 64'(bus.tx_data), 64'h00);
    chk("midrst_fifo_full", 64'(bus.fifo_full), 64'd0);
    chk("midrst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("midrst_idle", 64'(bus.idle), 64'd1);
    repeat (2) @(negedge clk);
    arst_l = 1'b1;
    @(negedge clk);
    put_pkt(4'h3, 2'd2, 5'h10, 5'h05, 64'h0123456789ABCDEF, 1'b1);
    end_pkts();
    n = 0;
    while (!bus.tx_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fresh_frame_sync", 64'(bus.tx_data), 64'hA5);
    wait_drain("fresh_drain", 2000);
    chk("post_rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
